// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between an
// instruction-fetch requester and a data requester.
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  if (LAT < 1 || LAT > 7) begin : g_lat_check
    $error("mem_arbiter: LAT must be in 1..7");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic       OWN_I   = 1'b0;
  localparam logic       OWN_D   = 1'b1;
  localparam logic [2:0] LAT_CNT = 3'(LAT);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= 3'd0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    busy      = 1'b1;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        // Grants are suppressed while reset is held so no requester sees a phantom accept.
        if (rst) begin
          if (i_req && (!d_req || last_q == OWN_D)) begin
            i_gnt = 1'b1;
          end else if (d_req) begin
            d_gnt = 1'b1;
          end
        end
        if (i_gnt) begin
          owner_d = OWN_I;
          last_d  = OWN_I;
          we_d    = 1'b0;
          addr_d  = i_addr;
          state_d = ACCESS;
        end else if (d_gnt) begin
          owner_d = OWN_D;
          last_d  = OWN_D;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        m_en    = 1'b1;
        m_we    = we_q;
        cnt_d   = LAT_CNT;
        state_d = WAIT;
      end

      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q == OWN_I) begin
              i_rdata_d = m_rdata;
            end else begin
              d_rdata_d = m_rdata;
            end
          end
        end
      end

      DONE: begin
        i_done  = (owner_q == OWN_I);
        d_done  = (owner_q == OWN_D);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width of all address ports.
REQ-002 Parameter DW, 32, data width of all data ports.
REQ-003 Parameter LAT, 2, memory read latency in cycles; legal range 1..7.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  1  instruction-fetch request.
REQ-007 i_addr  in  AW  instruction-fetch address.
REQ-008 i_gnt  out  1  fetch request accepted this cycle.
REQ-009 i_done  out  1  one-cycle pulse; fetch complete, i_rdata valid.
REQ-010 i_rdata  out  DW  registered fetch data.
REQ-011 d_req  in  1  data-access request.
REQ-012 d_we  in  1  data access is a write (1) or a read (0).
REQ-013 d_addr  in  AW  data-access address.
REQ-014 d_wdata  in  DW  data-access write data.
REQ-015 d_gnt  out  1  data request accepted this cycle.
REQ-016 d_done  out  1  one-cycle pulse; data access complete, d_rdata valid for reads.
REQ-017 d_rdata  out  DW  registered data-read data.
REQ-018 m_en  out  1  memory access strobe.
REQ-019 m_we  out  1  memory write enable.
REQ-020 m_addr  out  AW  memory address.
REQ-021 m_wdata  out  DW  memory write data.
REQ-022 m_rdata  in  DW  memory read data, valid LAT cycles after the m_en cycle.
REQ-023 busy  out  1  arbiter is not in IDLE.

Function
REQ-024 The FSM SHALL have four states: IDLE, ACCESS, WAIT, DONE.
REQ-025 In IDLE with any request, the FSM SHALL assert exactly one gnt combinationally and move to ACCESS at the next edge.
REQ-026 Arbitration SHALL be round-robin with a last_owner flag: sole requester wins; on a tie, the requester that is not last_owner wins.
REQ-027 At the grant edge, the FSM SHALL latch the owner, address, we (0 for I) and wdata, and update last_owner.
REQ-028 ACCESS SHALL last one cycle: m_en=1, with m_we, m_addr and m_wdata driven from the latched values.
REQ-029 Outside ACCESS: m_en=0 and m_we=0; m_addr and m_wdata hold their latched values.
REQ-030 WAIT SHALL last exactly LAT cycles using a 3-bit down-counter loaded with LAT on entry.
REQ-031 On the last WAIT edge, reads SHALL capture m_rdata into the owner's rdata register; writes SHALL leave both rdata registers unchanged.
REQ-032 DONE SHALL last one cycle, pulse the owner's done signal, then return to IDLE.
REQ-033 Latency: a grant in cycle t SHALL produce done in cycle t+2+LAT (t+4 for LAT=2).
REQ-034 i_rdata and d_rdata SHALL hold their values until the next read completion by the same owner.
REQ-035 Requests SHALL be ignored outside IDLE; a requester holds req until it sees gnt.
REQ-036 Each gnt SHALL be high only in IDLE, at most one per transaction, and never both in the same cycle.
REQ-037 No new grant SHALL occur in a DONE cycle; back-to-back transactions SHALL be spaced LAT+3 cycles apart.
REQ-038 busy SHALL be 0 in IDLE and 1 in every other state.

Reset
REQ-039 When rst=0, the arbiter SHALL asynchronously enter IDLE, including mid-transaction, and abandon the in-flight access without a done pulse.
REQ-040 Reset values: state=IDLE, last_owner=I, counter=0, m_en=0, m_we=0, m_addr=0, m_wdata=0, i_rdata=0, d_rdata=0, all done/gnt=0, busy=0.

Verification
REQ-041 Single fetch, LAT=2: i_req with i_addr=0x00000004, memory returns 0x8C010000 -> i_gnt in cycle t, m_en in t+1, i_done in t+4, i_rdata=0x8C010000.
REQ-042 Simultaneous i_req and d_req after reset (last_owner=I) -> d_gnt first; I is granted in the first IDLE after d_done; alternation continues while both hold req.
REQ-043 Data write: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> one m_en cycle with m_we=1 and the matching address/data; d_done LAT+2 cycles after the grant; d_rdata unchanged.
REQ-044 rst=0 asserted during WAIT -> immediate IDLE, busy=0, no done pulse; after release, a pending request is granted normally.
REQ-045 LAT=1 and LAT=7 builds: done arrives exactly at t+3 and t+9; no gnt while busy=1.
